aes_rr_sched: RTL and testbench

Round-robin scheduler that shares one `aes_top` AES-128 core among `NREQ` requesters. It arbitrates pending requests, captures the winner's operands and drives a clean rising edge on the core's `start_i`. It then holds the operands stable for the whole operation, waits for the core's `ready_o` pulse and routes the result back to the owning requester. A watchdog converts a hung core into an error response so requesters never deadlock.

---
 rtl/aes_rr_sched.sv | 162 ++++++++++++++++
 tb/tb_aes_rr_sched.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_rr_sched.sv
// Round-robin arbiter sharing one AES-128 core; grant in 1 cycle, response 1 cycle after core ready.
// Backpressure: requesters hold req_valid until req_ready; a hung core is released by a watchdog error.
module aes_rr_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_decrypt,
  input  logic [NREQ*128-1:0]  req_data,
  input  logic [NREQ*128-1:0]  req_key,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [127:0]         rsp_data,
  output logic                 rsp_err,
  output logic                 aes_start,
  output logic                 aes_decrypt,
  output logic [127:0]         aes_data,
  output logic [127:0]         aes_key,
  input  logic [127:0]         aes_dout,
  input  logic                 aes_ready,
  output logic                 busy,
  output logic                 stale
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    LAUNCH = 4'b0010,
    WAIT   = 4'b0100,
    RESP   = 4'b1000
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   ptr, ptr_n, gnt;
  logic            gnt_vld;
  logic [NREQ-1:0] gnt_oh, ptr_oh;
  logic [127:0]    sel_data, sel_key;
  logic            sel_dec;
  logic [CW-1:0]   cnt, cnt_n;
  logic [NREQ-1:0] req_ready_n, rsp_valid_n;
  logic [127:0]    rsp_data_n, data_n, key_n;
  logic            rsp_err_n, aes_start_n, dec_n, busy_n, stale_n;

  // Two passes give "first set bit above ptr, then wrap" without modulo arithmetic.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!gnt_vld && req_valid[j] && (PW'(j) > ptr)) begin
        gnt_vld = 1'b1;
        gnt     = PW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!gnt_vld && req_valid[j] && (PW'(j) <= ptr)) begin
        gnt_vld = 1'b1;
        gnt     = PW'(j);
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_key  = '0;
    sel_dec  = 1'b0;
    gnt_oh   = '0;
    ptr_oh   = '0;
    for (int j = 0; j < NREQ; j++) begin
      gnt_oh[j] = (PW'(j) == gnt);
      ptr_oh[j] = (PW'(j) == ptr);
      if (PW'(j) == gnt) begin
        sel_data = req_data[128*j +: 128];
        sel_key  = req_key[128*j +: 128];
        sel_dec  = req_decrypt[j];
      end
    end
  end

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    cnt_n       = '0;
    req_ready_n = '0;
    rsp_valid_n = '0;
    aes_start_n = 1'b0;
    rsp_data_n  = rsp_data;
    rsp_err_n   = rsp_err;
    data_n      = aes_data;
    key_n       = aes_key;
    dec_n       = aes_decrypt;
    // A completion outside WAIT belongs to no one (e.g. after a timeout).
    stale_n     = stale | (aes_ready && (state != WAIT));
    unique case (state)
      IDLE: begin
        if (gnt_vld) begin
          state_n     = LAUNCH;
          ptr_n       = gnt;
          req_ready_n = gnt_oh;
          aes_start_n = 1'b1;
          data_n      = sel_data;
          key_n       = sel_key;
          dec_n       = sel_dec;
        end
      end
      LAUNCH: state_n = WAIT;
      WAIT: begin
        cnt_n = (cnt == '1) ? cnt : cnt + 1'b1;
        if (aes_ready) begin
          state_n     = RESP;
          rsp_valid_n = ptr_oh;
          rsp_data_n  = aes_dout;
          rsp_err_n   = 1'b0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_n     = RESP;
          rsp_valid_n = ptr_oh;
          rsp_data_n  = '0;
          rsp_err_n   = 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= PW'(NREQ - 1);
      cnt         <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      aes_start   <= 1'b0;
      aes_decrypt <= 1'b0;
      aes_data    <= '0;
      aes_key     <= '0;
      busy        <= 1'b0;
      stale       <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      cnt         <= cnt_n;
      req_ready   <= req_ready_n;
      rsp_valid   <= rsp_valid_n;
      rsp_data    <= rsp_data_n;
      rsp_err     <= rsp_err_n;
      aes_start   <= aes_start_n;
      aes_decrypt <= dec_n;
      aes_data    <= data_n;
      aes_key     <= key_n;
      busy        <= busy_n;
      stale       <= stale_n;
    end
  end

endmodule

// File: tb/tb_aes_rr_sched.sv
// Scoreboard bench for aes_rr_sched with a behavioural core of programmable latency.
module tb_aes_rr_sched;

  localparam int NREQ = 4;
  localparam int TMO  = 64;
  localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct packed {
    logic         dec;
    logic [127:0] data;
    logic [127:0] key;
  } job_t;

  typedef struct {
    int           idx;
    logic [127:0] data;
    logic         err;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid, req_decrypt, req_ready, rsp_valid;
  logic [NREQ*128-1:0] req_data, req_key;
  logic [127:0]        rsp_data, aes_data, aes_key, aes_dout;
  logic                rsp_err, aes_start, aes_decrypt, aes_ready, busy, stale;

  aes_rr_sched #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_decrypt (req_decrypt),
    .req_data    (req_data),
    .req_key     (req_key),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .aes_start   (aes_start),
    .aes_decrypt (aes_decrypt),
    .aes_data    (aes_data),
    .aes_key     (aes_key),
    .aes_dout    (aes_dout),
    .aes_ready   (aes_ready),
    .busy        (busy),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Known AES-128 vectors; anything else gets a cheap reversible-looking mix.
  function automatic logic [127:0] model(input job_t j);
    if (j.key == K && !j.dec && j.data == PT) return CT;
    if (j.key == K &&  j.dec && j.data == CT) return PT;
    return j.dec ? (j.data ^ ~j.key) : ({j.data[63:0], j.data[127:64]} ^ j.key);
  endfunction

  function automatic job_t mk_job(input logic dec, input logic [127:0] data, input logic [127:0] key);
    job_t j;
    j.dec  = dec;
    j.data = data;
    j.key  = key;
    return j;
  endfunction

  function automatic job_t gen_job(input int i, input int k);
    return mk_job(((i + k) % 2) == 1,
                  {32'(i), 32'(k), 32'h5eed0000 + 32'(i), 32'hc0ffee00},
                  K ^ {4{32'(k * 7 + i)}});
  endfunction

  exp_t exp_q[$];
  int   gnt_q[$];
  int   rsp_cnt = 0;

  // Behavioural core: ready pulses core_lat cycles after a start, result taken from
  // the operands present at completion so any mid-run operand change shows up.
  int core_lat  = 10;
  int start_cyc = 0;
  int ready_cyc = 0;
  initial begin : core_model
    int left;
    left      = 0;
    aes_ready = 1'b0;
    aes_dout  = '0;
    forever begin
      @(posedge clk); #1;
      aes_ready = 1'b0;
      if (!rst_n) begin
        left = 0;
      end else if (left > 0) begin
        left--;
        if (left == 0) begin
          aes_dout  = model(mk_job(aes_decrypt, aes_data, aes_key));
          aes_ready = 1'b1;
          ready_cyc = cyc;
        end
      end else if (aes_start) begin
        start_cyc = cyc;
        left      = core_lat;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    int   gi;
    int   low_run;
    bit   seen_start;
    low_run    = 0;
    seen_start = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        seen_start = 0;
        low_run    = 0;
      end else begin
        if (aes_start) begin
          if (seen_start) check("start_gap", 128'(low_run >= 3), 128'(1));
          seen_start = 1;
          low_run    = 0;
        end else begin
          low_run++;
        end
        if (req_ready != '0) begin
          if (gnt_q.size() == 0) begin
            check("unexp_grant", 128'(req_ready), 128'(0));
          end else begin
            gi = gnt_q.pop_front();
            check("grant", 128'(req_ready), 128'(1 << gi));
            check("start_with_grant", 128'(aes_start), 128'(1));
          end
        end
        if (rsp_valid != '0) begin
          rsp_cnt++;
          if (exp_q.size() == 0) begin
            check("unexp_rsp", 128'(rsp_valid), 128'(0));
          end else begin
            e = exp_q.pop_front();
            check("rsp_owner", 128'(rsp_valid), 128'(1 << e.idx));
            check("rsp_data", rsp_data, e.data);
            check("rsp_err", 128'(rsp_err), 128'(e.err));
            check("rsp_lat", 128'(cyc), 128'(e.err ? start_cyc + TMO + 1 : ready_cyc + 1));
          end
        end
      end
    end
  end

  logic [NREQ-1:0] rel;
  int rem[NREQ];
  int ser[NREQ];

  task automatic present(input int i, input job_t j, input logic err);
    exp_t e;
    req_valid[i]             = 1'b1;
    req_decrypt[i]           = j.dec;
    req_data[128*i +: 128]   = j.data;
    req_key[128*i +: 128]    = j.key;
    e.idx  = i;
    e.data = err ? '0 : model(j);
    e.err  = err;
    gnt_q.push_back(i);
    exp_q.push_back(e);
  endtask

  // Requesters release (or refill) on the cycle after they saw req_ready.
  task automatic tick();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      if (rel[i]) begin
        if (rem[i] > 0) begin
          rem[i]--;
          ser[i]++;
          present(i, gen_job(i, ser[i]), 1'b0);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
    rel = rst_n ? req_ready : '0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || req_valid != '0 || busy) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 128'(n < budget), 128'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 128'(req_ready), 128'(0));
    check({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
    check({tag, "_rsp_data"}, rsp_data, 128'(0));
    check({tag, "_rsp_err"}, 128'(rsp_err), 128'(0));
    check({tag, "_aes_start"}, 128'(aes_start), 128'(0));
    check({tag, "_aes_decrypt"}, 128'(aes_decrypt), 128'(0));
    check({tag, "_aes_data"}, aes_data, 128'(0));
    check({tag, "_aes_key"}, aes_key, 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_stale"}, 128'(stale), 128'(0));
  endtask

  initial begin : main
    int rsp_before;
    rst_n       = 1'b0;
    req_valid   = '0;
    req_decrypt = '0;
    req_data    = '0;
    req_key     = '0;
    rel         = '0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0;
      ser[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // Single encrypt on requester 0: grant one cycle after valid.
    core_lat = 10;
    present(0, mk_job(1'b0, PT, K), 1'b0);
    tick();
    check("grant_lat", 128'(req_ready), 128'(4'b0001));
    check("start_lat", 128'(aes_start), 128'(1));
    check("busy_launch", 128'(busy), 128'(1));
    check("aes_data_route", aes_data, PT);
    check("aes_key_route", aes_key, K);
    check("aes_dec_route", 128'(aes_decrypt), 128'(0));
    wait_done("enc_done", 100);

    // Decrypt round trip on requester 2.
    present(2, mk_job(1'b1, CT, K), 1'b0);
    wait_done("dec_done", 100);

    // Random decrypt on requester 3 leaves the pointer at 3.
    present(3, mk_job(1'b1, {$urandom, $urandom, $urandom, $urandom},
                      {$urandom, $urandom, $urandom, $urandom}), 1'b0);
    wait_done("rnd_done", 100);

    // Fairness: all four held valid for two jobs each.
    rsp_before = rsp_cnt;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 1;
      ser[i] = 0;
      present(i, gen_job(i, 0), 1'b0);
    end
    wait_done("fair_done", 400);
    check("fair_count", 128'(rsp_cnt - rsp_before), 128'(8));

    // Hung core: timeout error, then a late completion in IDLE marks stale.
    core_lat   = 75;
    rsp_before = rsp_cnt;
    present(1, gen_job(1, 9), 1'b1);
    wait_done("tmo_done", 200);
    check("stale_before_late", 128'(stale), 128'(0));
    repeat (20) tick();
    check("stale_after_late", 128'(stale), 128'(1));
    check("late_no_rsp", 128'(rsp_cnt - rsp_before), 128'(1));

    // Completion on the last watchdog count wins over the timeout.
    core_lat = TMO;
    present(0, gen_job(0, 11), 1'b0);
    wait_done("tie_done", 200);

    // Reset during WAIT: no response, everything back to reset values.
    core_lat = 30;
    present(3, gen_job(3, 12), 1'b0);
    repeat (6) tick();
    check("busy_in_wait", 128'(busy), 128'(1));
    rsp_before = rsp_cnt;
    rst_n = 1'b0;
    exp_q.delete();
    gnt_q.delete();
    rel = '0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) tick();
    check("midrst_no_rsp", 128'(rsp_cnt - rsp_before), 128'(0));

    // After reset requester 0 has priority over requester 2.
    core_lat = 10;
    present(0, gen_job(0, 13), 1'b0);
    present(2, gen_job(2, 14), 1'b0);
    tick();
    check("post_rst_grant", 128'(req_ready), 128'(4'b0001));
    wait_done("post_rst_done", 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
